// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the pipeline memory-port arbiter.
//
//   Contents:
//     DEF_ADDR_W / DEF_DATA_W : default address and data widths.
//     DEF_STARVE_LIMIT        : default number of consecutive data grants that
//                               may pass a waiting fetch.
//     CNT_W                   : width of the starvation counter (limit <= 15).
//     arb_state_e             : arbiter state encoding.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned CNT_W            = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no transfer in flight; grant decision made here
    BUSY_I = 2'd1,  // instruction fetch owns the memory
    BUSY_D = 2'd2   // load/store owns the memory
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
//   Counts data grants that were given while a fetch was waiting. Saturates at
//   LIMIT so the arbiter can force the next grant to the fetch port.
//
//   Ports:
//     clk      : clock, rising edge.
//     rst      : synchronous, active-high reset (count -> 0).
//     inc      : one data grant passed a waiting fetch.
//     clr      : a fetch was granted; takes priority over inc.
//     count    : current count, 0..LIMIT.
//     at_limit : count == LIMIT.
// -----------------------------------------------------------------------------
module arb_starve_counter
  import cpu_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: always_comb assigns a default to every output first; a path that
  // leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT_C)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and the
//   load/store stage (MEM). One transfer at a time; data normally wins, but a
//   fetch is forced once STARVE_LIMIT data grants have passed a waiting fetch.
//
//   Ports:
//     clk, rst            : clock and synchronous active-high reset.
//     if_req, if_addr     : fetch request (held until if_valid) and PC.
//     if_rdata, if_valid  : fetched word and its one-cycle completion pulse.
//     d_read, d_write     : load / store request (held until d_valid);
//                           both high behaves as a store.
//     d_addr, d_wdata     : data address and store data.
//     d_rdata, d_valid    : load data and one-cycle completion pulse.
//     m_req, m_we         : registered memory request / write enable.
//     m_addr, m_wdata     : registered memory address / write data.
//     m_rdata, m_ready    : memory read data and transfer-complete strobe.
//     stall_if            : freeze PC and IF/ID.
//     stall_mem           : freeze the whole pipeline.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  // data port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  // pipeline stalls
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [CNT_W-1:0] STARVE_LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;

  logic              d_pend;
  logic              i_pend;
  logic              force_fetch;
  logic              cnt_inc;
  logic              cnt_clr;
  logic [CNT_W-1:0]  starve_count;
  logic              starve_at_limit;

  // A requester whose valid pulse is high this cycle has just been served;
  // its request line may still be up, but it must not be granted again.
  assign d_pend = (d_read | d_write) & ~d_valid_q;
  assign i_pend = if_req & ~if_valid_q;

  assign force_fetch = (starve_count == STARVE_LIMIT_C);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .count    (starve_count),
    .at_limit (starve_at_limit)
  );

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // m_ready is deliberately ignored here: no transfer is in flight.
        if (d_pend && !(i_pend && force_fetch)) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_addr_d  = d_addr;
          m_we_d    = d_write;  // read+write together resolves to a store
          m_wdata_d = d_wdata;
          // Only a grant that actually passes a waiting fetch counts.
          cnt_inc   = if_req & ~starve_at_limit;
        end else if (i_pend) begin
          state_d   = BUSY_I;
          m_req_d   = 1'b1;
          m_addr_d  = if_addr;
          m_we_d    = 1'b0;
          m_wdata_d = d_wdata;
          cnt_clr   = 1'b1;
        end
      end

      BUSY_I: begin
        if (m_ready) begin
          state_d    = IDLE;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = m_rdata;
        end
      end

      BUSY_D: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          d_valid_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;  // a store leaves the last load data intact
          end
        end
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well as the control flops,
      // so the memory bus and the rdata outputs never present X after reset.
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;

  // A pending data access freezes everything, so it also freezes fetch.
  assign stall_mem = d_pend;
  assign stall_if  = i_pend | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: reset/stall vector table, the
//   hand-written corner sequences, then randomized traffic against a
//   transaction-level model with a word-addressed reference memory.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        stall_if;
  logic        stall_mem;

  int n_checks = 0;
  int n_err    = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic if_req;
    logic d_read;
    logic d_write;
    logic e_stall_if;
    logic e_stall_mem;
  } vec_t;

  // random-phase state
  logic [31:0] mem_arr [16];
  logic [31:0] ref_mem [16];

  initial begin
    vec_t tbl [8];
    int   g_kind [6];
    int   exp_g  [6];
    int   n_g;
    logic prev_req;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // ---------------- reset state and stall table (held in reset) -----------
    do_reset();
    rst = 1'b1;
    tick();
    check("rst_m_req", m_req, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    for (int i = 0; i < 8; i++) begin
      if_req  = tbl[i].if_req;
      d_read  = tbl[i].d_read;
      d_write = tbl[i].d_write;
      #1;
      check($sformatf("tbl%0d_stall_if", i), stall_if, tbl[i].e_stall_if);
      check($sformatf("tbl%0d_stall_mem", i), stall_mem, tbl[i].e_stall_mem);
    end
    tick();
    check("tbl_m_req_in_reset", m_req, 0);

    // ---------------- fetch only ---------------------------------------------
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; m_ready = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    check("t1_stall_if_c0", stall_if, 1);
    check("t1_m_req_c0", m_req, 0);
    tick();
    check("t1_m_req_c1", m_req, 1);
    check("t1_m_addr_c1", m_addr, 32'h40);
    check("t1_m_we_c1", m_we, 0);
    check("t1_stall_if_c1", stall_if, 1);
    check("t1_if_valid_c1", if_valid, 0);
    tick();
    check("t1_if_valid_c2", if_valid, 1);
    check("t1_if_rdata_c2", if_rdata, 32'h1234_5678);
    check("t1_m_req_c2", m_req, 0);
    if_req = 1'b0;
    tick();
    check("t1_if_valid_c3", if_valid, 0);
    check("t1_m_req_c3", m_req, 0);

    // ---------------- store with wait states ---------------------------------
    do_reset();
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    m_ready = 1'b0; m_rdata = 32'hBAD0_BAD0;
    #1;
    check("t2_stall_mem_c0", stall_mem, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t2_m_req_c%0d", k), m_req, 1);
      check($sformatf("t2_m_we_c%0d", k), m_we, 1);
      check($sformatf("t2_m_addr_c%0d", k), m_addr, 32'h100);
      check($sformatf("t2_m_wdata_c%0d", k), m_wdata, 32'hDEAD_BEEF);
      check($sformatf("t2_d_valid_c%0d", k), d_valid, 0);
      check($sformatf("t2_stall_mem_c%0d", k), stall_mem, 1);
      if (k == 4) m_ready = 1'b1;
    end
    tick();
    check("t2_d_valid_pulse", d_valid, 1);
    check("t2_d_rdata_kept", d_rdata, 0);
    check("t2_m_req_done", m_req, 0);
    d_write = 1'b0; m_ready = 1'b0;
    tick();
    check("t2_d_valid_single", d_valid, 0);

    // ---------------- simultaneous requests ----------------------------------
    do_reset();
    if_req = 1'b1; if_addr = 32'h80; d_read = 1'b1; d_addr = 32'h200;
    m_ready = 1'b1; m_rdata = 32'hD0D0_0001;
    tick();
    check("t3_m_req_c1", m_req, 1);
    check("t3_data_first", m_addr, 32'h200);
    check("t3_m_we_c1", m_we, 0);
    tick();
    check("t3_d_valid_c2", d_valid, 1);
    check("t3_d_rdata_c2", d_rdata, 32'hD0D0_0001);
    // d_read is left high this cycle: the arbiter must still turn to the fetch.
    m_rdata = 32'h1111_2222;
    tick();
    check("t3_fetch_second", m_addr, 32'h80);
    check("t3_m_req_c3", m_req, 1);
    check("t3_d_valid_c3", d_valid, 0);
    d_read = 1'b0;
    tick();
    check("t3_if_valid_c4", if_valid, 1);
    check("t3_if_rdata_c4", if_rdata, 32'h1111_2222);
    if_req = 1'b0;
    tick();
    check("t3_idle_c5", m_req, 0);

    // ---------------- starvation limit ---------------------------------------
    // The fetch line drops during each d_valid cycle so that every new load
    // meets the fetch in an idle cycle where both are pending.
    do_reset();
    d_read = 1'b1; d_addr = 32'h0000_0D00; if_req = 1'b1; if_addr = 32'h0000_0100;
    m_ready = 1'b1; m_rdata = 32'h0;
    exp_g = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 6; i++) g_kind[i] = -1;
    n_g = 0;
    prev_req = 1'b0;
    for (int cyc = 0; cyc < 60 && n_g < 6; cyc++) begin
      tick();
      if (m_req && !prev_req) begin
        g_kind[n_g] = (m_addr == 32'h0000_0D00) ? 1 : 0;
        if (g_kind[n_g] == 0) check("t4_cnt_clear", 32'(dut.u_starve.count), 0);
        n_g++;
      end
      prev_req = m_req;
      if_req   = d_valid ? 1'b0 : 1'b1;
    end
    check("t4_grant_count", n_g, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t4_grant%0d_is_data", i), g_kind[i], exp_g[i]);

    // ---------------- reset mid-transfer -------------------------------------
    do_reset();
    d_read = 1'b1; d_addr = 32'h300; m_ready = 1'b0; m_rdata = 32'hCAFE_0001;
    tick();
    check("t5_busy", m_req, 1);
    tick();
    rst = 1'b1; m_ready = 1'b1;
    tick();
    check("t5_rst_m_req", m_req, 0);
    check("t5_rst_d_valid", d_valid, 0);
    check("t5_rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick();
    check("t5_no_pulse", d_valid, 0);
    check("t5_regrant", m_req, 1);
    check("t5_regrant_addr", m_addr, 32'h300);
    tick();
    check("t5_d_valid", d_valid, 1);
    check("t5_d_rdata", d_rdata, 32'hCAFE_0001);
    d_read = 1'b0; m_ready = 1'b0;
    tick();
    check("t5_d_valid_single", d_valid, 0);

    // ---------------- read and write together --------------------------------
    do_reset();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h44; d_wdata = 32'h5555_AAAA;
    m_ready = 1'b1; m_rdata = 32'h7777_7777;
    tick();
    check("t6_m_req", m_req, 1);
    check("t6_m_we", m_we, 1);
    check("t6_m_wdata", m_wdata, 32'h5555_AAAA);
    tick();
    check("t6_d_valid", d_valid, 1);
    check("t6_d_rdata_kept", d_rdata, 0);
    d_read = 1'b0; d_write = 1'b0;
    tick();
    check("t6_d_valid_single", d_valid, 0);

    // ---------------- randomized traffic vs. reference model -----------------
    begin
      bit          i_act, d_act, d_we_r;
      logic [31:0] i_a, d_a, d_wd;
      bit          busy_i, busy_d;
      int          starve;
      int          kind;
      logic        e_req, e_we, e_ifv, e_dv;
      logic [31:0] e_addr, e_wdata, e_ifr, e_dr;
      bit          p_i_elig, p_d_elig, p_ready, p_if_req;
      bit          in_run;

      do_reset();
      for (int i = 0; i < 16; i++) begin
        mem_arr[i] = $urandom;
        ref_mem[i] = mem_arr[i];
      end
      i_act = 0; d_act = 0; d_we_r = 0; i_a = 0; d_a = 0; d_wd = 0;
      busy_i = 0; busy_d = 0; starve = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_ifr = 0; e_dr = 0;
      p_i_elig = 0; p_d_elig = 0; p_ready = 0; p_if_req = 0;

      for (int cyc = 0; cyc < 1200; cyc++) begin
        in_run = (cyc < 600);
        tick();

        // model: what the edge just taken must have done
        e_ifv = 1'b0;
        e_dv  = 1'b0;
        if (busy_i) begin
          if (p_ready) begin
            busy_i = 0; e_ifv = 1'b1; e_req = 1'b0;
            e_ifr  = ref_mem[i_a[5:2]];
          end
        end else if (busy_d) begin
          if (p_ready) begin
            busy_d = 0; e_dv = 1'b1; e_req = 1'b0;
            if (d_we_r) ref_mem[d_a[5:2]] = d_wd;
            else        e_dr = ref_mem[d_a[5:2]];
          end
        end else if (p_d_elig && !(p_i_elig && starve == LIMIT)) begin
          busy_d = 1; e_req = 1'b1; e_addr = d_a; e_we = d_we_r; e_wdata = d_wd;
          if (p_if_req && starve < LIMIT) starve++;
        end else if (p_i_elig) begin
          busy_i = 1; e_req = 1'b1; e_addr = i_a; e_we = 1'b0;
          starve = 0;
        end

        check("rnd_m_req", m_req, e_req);
        if (e_req) begin
          check("rnd_m_addr", m_addr, e_addr);
          check("rnd_m_we", m_we, e_we);
          if (e_we) check("rnd_m_wdata", m_wdata, e_wdata);
        end
        check("rnd_if_valid", if_valid, e_ifv);
        check("rnd_d_valid", d_valid, e_dv);
        check("rnd_if_rdata", if_rdata, e_ifr);
        check("rnd_d_rdata", d_rdata, e_dr);

        // requesters: retire on completion, maybe issue a new request
        if (e_ifv) i_act = 0;
        if (e_dv)  d_act = 0;
        if (in_run && !i_act && $urandom_range(0, 3) == 0) begin
          i_act = 1; i_a = $urandom;
        end
        if (in_run && !d_act && $urandom_range(0, 2) == 0) begin
          d_act  = 1;
          kind   = int'($urandom_range(0, 2));  // 0 load, 1 store, 2 both lines
          d_we_r = (kind != 0);
          d_a    = $urandom;
          d_wd   = $urandom;
        end
        if_req  = i_act;
        if_addr = i_act ? i_a : $urandom;
        d_read  = d_act && (kind != 1);
        d_write = d_act && d_we_r;
        d_addr  = d_act ? d_a : $urandom;
        d_wdata = d_act ? d_wd : $urandom;

        // memory: random wait states, data only meaningful with m_ready
        m_ready = ($urandom_range(0, 2) != 0);
        if (m_ready && m_req) begin
          m_rdata = mem_arr[m_addr[5:2]];
          if (m_we) mem_arr[m_addr[5:2]] = m_wdata;
        end else begin
          m_rdata = $urandom;
        end

        p_i_elig = i_act && !e_ifv;
        p_d_elig = d_act && !e_dv;
        p_if_req = i_act;
        p_ready  = m_ready;

        #1;
        check("rnd_stall_mem", stall_mem, p_d_elig);
        check("rnd_stall_if", stall_if, p_i_elig || p_d_elig);

        if (!in_run && !i_act && !d_act && !busy_i && !busy_d) break;
      end
      check("rnd_drained", {30'd0, i_act, d_act}, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences one shared single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Grants one requester at a time and drives the variable-latency memory handshake.
- Returns read data with a one-cycle valid pulse.
- Generates stall signals that the CPU controller combines with its hazard stalls (PcWrite/IFIDLoad off for stall_if; whole-pipeline freeze for stall_mem).

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending before a fetch is forced; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF stage requests a fetch; held stable until if_valid.
- if_addr  in  ADDR_W  fetch address (the PC).
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- d_read  in  1  MEM stage load request; held until d_valid.
- d_write  in  1  MEM stage store request; held until d_valid.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle pulse: data access complete.
- m_req  out  1  memory request; registered.
- m_we  out  1  memory write enable; registered.
- m_addr  out  ADDR_W  memory address; registered.
- m_wdata  out  DATA_W  memory write data; registered.
- m_rdata  in  DATA_W  memory read data, valid when m_ready is high.
- m_ready  in  1  memory completes the current transfer this cycle.
- stall_if  out  1  freeze PC and IF/ID register.
- stall_mem  out  1  freeze the whole pipeline.

Behaviour:
- Reset:
  - State goes to IDLE; starvation count to 0.
  - m_req, m_we, if_valid and d_valid go to 0.
  - m_addr, m_wdata, if_rdata and d_rdata go to 0.
  - Reset asserted mid-transfer abandons the transfer; no valid pulse follows it.
- FSM states: IDLE, BUSY_I, BUSY_D.
- Eligibility in IDLE:
  - d_pend = (d_read | d_write) & ~d_valid.
  - i_pend = if_req & ~if_valid.
  - A requester whose valid pulse is high in this cycle is already served and is not eligible.
- Grant rule in IDLE:
  - Only d_pend → BUSY_D.
  - Only i_pend → BUSY_I.
  - Both pending → BUSY_D, unless starve_cnt == STARVE_LIMIT, then BUSY_I.
  - Neither pending → stay in IDLE.
- On grant, registered on the same edge:
  - m_req ← 1.
  - m_addr ← the granted address.
  - m_we ← d_write (BUSY_D only; 0 for a fetch).
  - m_wdata ← d_wdata.
- d_read and d_write both high is treated as a write.
- BUSY_x:
  - m_req and the captured fields are held constant.
  - On m_ready: m_req ← 0 and state → IDLE.
  - On the same edge, the matching valid ← 1 for exactly one cycle.
  - On the same edge, the matching rdata ← m_rdata, for reads only; d_rdata holds its old value on a write.
- Latency:
  - A request seen in IDLE at cycle N gives m_req high in cycle N+1.
  - If m_ready is high at N+1, valid is high at N+2.
  - Each extra wait cycle of memory adds one cycle.
  - Back-to-back transfers: minimum period 2 cycles (the IDLE/valid cycle, then BUSY).
- Starvation counter:
  - On a D grant while if_req is high: increments, saturating at STARVE_LIMIT.
  - On an I grant: clears to 0.
  - On a D grant while if_req is low: unchanged.
- Stalls (combinational):
  - stall_mem = d_pend.
  - stall_if = i_pend | stall_mem.
- Data integrity:
  - m_ready while in IDLE is ignored.
  - The rdata outputs hold their value between valid pulses.

Decomposition:
- Shared package (cpu_pkg): state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2); default widths ADDR_W/DATA_W.
- One natural sub-module: arb_starve_counter.
  - Inputs: inc, clr.
  - Outputs: count and at_limit.
  - Saturating at STARVE_LIMIT; synchronous reset.

Test Plan:
- Reset then fetch only: if_req=1, if_addr=0x40, m_ready=1 every cycle.
  - Expect m_req at cycle 1 with m_addr=0x40 and m_we=0.
  - Expect if_valid pulse at cycle 2 with if_rdata=m_rdata.
  - Expect stall_if=1 in cycles 0–1.
- Store with wait states: d_write=1, d_addr=0x100, d_wdata=0xDEADBEEF; m_ready low for 3 busy cycles, then high.
  - Expect m_we=1, and m_addr and m_wdata held for 4 cycles.
  - Expect exactly one d_valid pulse; d_rdata unchanged.
  - Expect stall_mem=1 throughout.
- Simultaneous requests: if_req and d_read both high.
  - Expect data served first, then the fetch.
  - Expect no re-grant of data in the cycle d_valid is high.
- Starvation with STARVE_LIMIT=4: if_req held high, 6 back-to-back loads.
  - Expect the grant order D,D,D,D,I,D.
  - Expect the counter to clear after the I grant.
- Reset mid-transfer: rst asserted in BUSY_D.
  - Expect IDLE, m_req=0 and no d_valid pulse on the next edge.
  - Expect normal operation after reset is released.
- d_read and d_write both high: expect m_we=1 and a single d_valid pulse.
